// File: rtl/jtag_driver.sv
// rtl/jtag_driver.sv - command-driven JTAG master that bit-bangs tck/tms/tdi/trst and captures tdo
//
// Purpose: accepts SEQ / SHIFT / TRST commands on a valid/ready interface, plays them
// out on the JTAG pins from the clk domain and returns the captured tdo bits on a
// valid/ready response interface.
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   cmd_valid / cmd_ready    command handshake (ready only while idle)
//   cmd_op                   0=SEQ, 1=SHIFT, 2=TRST pulse, 3=reserved
//   cmd_len                  bit count (0 and op 3 complete immediately, >MAX_LEN clamped)
//   cmd_exit                 SHIFT only: tms=1 on the final bit
//   cmd_tms, cmd_tdi         per-bit tms / tdi, LSB first
//   rsp_valid / rsp_ready    response handshake
//   rsp_tdo                  captured tdo, bit i = sample for bit i
//   tck, tms, tdi, trst      JTAG pins (registered); tdo from the TAP
module jtag_driver #(
    parameter int CLK_DIV = 4,
    parameter int MAX_LEN = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [5:0]         cmd_len,
    input  logic               cmd_exit,
    input  logic [MAX_LEN-1:0] cmd_tms,
    input  logic [MAX_LEN-1:0] cmd_tdi,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [MAX_LEN-1:0] rsp_tdo,
    output logic               tck,
    output logic               tms,
    output logic               tdi,
    output logic               trst,
    input  logic               tdo
);

    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int PW = $clog2(2 * CLK_DIV);

    localparam logic [PW-1:0] HALF_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] TRST_LAST = PW'(2 * CLK_DIV - 1);
    localparam logic [5:0]    LEN_MAX   = 6'(MAX_LEN);

    localparam logic [1:0] OP_SEQ   = 2'd0;
    localparam logic [1:0] OP_SHIFT = 2'd1;
    localparam logic [1:0] OP_TRST  = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_TRST,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      phase_q, phase_d;
    logic [IW-1:0]      bit_q, bit_d;
    logic [5:0]         len_q, len_d;
    logic [1:0]         op_q, op_d;
    logic               exit_q, exit_d;
    logic [MAX_LEN-1:0] tmsv_q, tmsv_d;
    logic [MAX_LEN-1:0] tdiv_q, tdiv_d;
    logic [MAX_LEN-1:0] tdo_q, tdo_d;
    logic               tck_q, tck_d;
    logic               tms_q, tms_d;
    logic               tdi_q, tdi_d;
    logic               trst_q, trst_d;

    logic [5:0]         len_in;
    logic [IW-1:0]      bit_nxt;
    logic               last_bit;

    // tms for bit i: SEQ takes the vector, SHIFT is low except an optional exit on the last bit
    function automatic logic pick_tms(input logic [1:0]         op,
                                      input logic               ex,
                                      input logic [MAX_LEN-1:0] v,
                                      input logic [IW-1:0]      i,
                                      input logic [5:0]         len);
        if (op == OP_SEQ) begin
            return v[i];
        end
        return ex && (6'(i) == len - 6'd1);
    endfunction

    assign len_in   = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
    assign bit_nxt  = bit_q + 1'b1;
    assign last_bit = (6'(bit_q) == len_q - 6'd1);

    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign rsp_valid = (state_q == S_DONE);
    assign rsp_tdo   = tdo_q;
    assign tck       = tck_q;
    assign tms       = tms_q;
    assign tdi       = tdi_q;
    assign trst      = trst_q;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        len_d   = len_q;
        op_d    = op_q;
        exit_d  = exit_q;
        tmsv_d  = tmsv_q;
        tdiv_d  = tdiv_q;
        tdo_d   = tdo_q;
        tck_d   = tck_q;
        tms_d   = tms_q;
        tdi_d   = tdi_q;
        trst_d  = trst_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    len_d   = len_in;
                    exit_d  = cmd_exit;
                    tmsv_d  = cmd_tms;
                    tdiv_d  = cmd_tdi;
                    tdo_d   = '0;
                    bit_d   = '0;
                    phase_d = '0;
                    tck_d   = 1'b0;
                    if (cmd_op == OP_TRST) begin
                        state_d = S_TRST;
                        trst_d  = 1'b0;
                        tms_d   = 1'b1;
                    end else if ((cmd_op != OP_SEQ && cmd_op != OP_SHIFT) || len_in == 6'd0) begin
                        state_d = S_DONE;
                    end else begin
                        // bit 0 pins are set up in the same edge that enters LOW
                        state_d = S_LOW;
                        tms_d   = pick_tms(cmd_op, cmd_exit, cmd_tms, '0, len_in);
                        tdi_d   = cmd_tdi[0];
                    end
                end
            end

            S_LOW: begin
                if (phase_q == HALF_LAST) begin
                    phase_d = '0;
                    state_d = S_HIGH;
                    tck_d   = 1'b1;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            S_HIGH: begin
                if (phase_q == HALF_LAST) begin
                    // last clk of the high phase: the TAP has not yet seen the falling edge
                    phase_d       = '0;
                    tck_d         = 1'b0;
                    tdo_d[bit_q]  = tdo;
                    if (last_bit) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOW;
                        bit_d   = bit_nxt;
                        tms_d   = pick_tms(op_q, exit_q, tmsv_q, bit_nxt, len_q);
                        tdi_d   = tdiv_q[bit_nxt];
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            S_TRST: begin
                if (phase_q == TRST_LAST) begin
                    phase_d = '0;
                    trst_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end

            S_DONE: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            len_q   <= '0;
            op_q    <= '0;
            exit_q  <= 1'b0;
            tmsv_q  <= '0;
            tdiv_q  <= '0;
            tdo_q   <= '0;
            tck_q   <= 1'b0;
            tms_q   <= 1'b1;
            tdi_q   <= 1'b0;
            trst_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            len_q   <= len_d;
            op_q    <= op_d;
            exit_q  <= exit_d;
            tmsv_q  <= tmsv_d;
            tdiv_q  <= tdiv_d;
            tdo_q   <= tdo_d;
            tck_q   <= tck_d;
            tms_q   <= tms_d;
            tdi_q   <= tdi_d;
            trst_q  <= trst_d;
        end
    end

endmodule

// File: tb/tb_jtag_driver.sv
// tb/tb_jtag_driver.sv - self-checking bench for jtag_driver with a TAP/BSR model and an 8-bit shift device
module tb_jtag_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = '0;
    logic [5:0]  cmd_len = '0;
    logic        cmd_exit = 1'b0;
    logic [31:0] cmd_tms = '0;
    logic [31:0] cmd_tdi = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_tdo;
    logic        tck, tms, tdi, trst;
    logic        tdo_w;

    int n_asserts = 0;
    int n_fail = 0;

    logic [31:0] exp_q[$];
    logic        tms_log[$];

    always #5 clk = ~clk;

    jtag_driver #(.CLK_DIV(4), .MAX_LEN(32)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
        .cmd_exit(cmd_exit), .cmd_tms(cmd_tms), .cmd_tdi(cmd_tdi),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tdo(rsp_tdo),
        .tck(tck), .tms(tms), .tdi(tdi), .trst(trst), .tdo(tdo_w)
    );

    always @(posedge tck) tms_log.push_back(tms);

    // ---------------- 8-bit shift device (LSB out first, tdo changes on falling tck)
    logic       use_sr8 = 1'b0;
    logic       sr8_load = 1'b0;
    logic [7:0] sr8 = '0;
    logic       tdo8 = 1'b0;

    always @(posedge tck or negedge tck or posedge sr8_load) begin
        if (sr8_load) begin
            sr8  <= 8'h3C;
            tdo8 <= 1'b0;
        end else if (use_sr8) begin
            if (tck) sr8 <= {tdi, sr8[7:1]};
            else     tdo8 <= sr8[0];
        end
    end

    // ---------------- TAP model with 2-bit IR and 5-cell BSR around a full adder
    typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                              SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_t;
    tap_t       tap_st = TLR;
    logic [1:0] ir = 2'b11;
    logic [1:0] irsr = 2'b00;
    logic [4:0] dr = '0;
    logic [4:0] upd = '0;
    logic       tdo_tap = 1'b0;
    logic       fa_sum, fa_carry;

    assign fa_sum   = upd[0] ^ upd[1] ^ upd[2];
    assign fa_carry = (upd[0] & upd[1]) | (upd[2] & (upd[0] ^ upd[1]));
    assign tdo_w    = use_sr8 ? tdo8 : tdo_tap;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TLR:   return m ? TLR   : RTI;
            RTI:   return m ? SELDR : RTI;
            SELDR: return m ? SELIR : CAPDR;
            CAPDR: return m ? EX1DR : SHDR;
            SHDR:  return m ? EX1DR : SHDR;
            EX1DR: return m ? UPDR  : PADR;
            PADR:  return m ? EX2DR : PADR;
            EX2DR: return m ? UPDR  : SHDR;
            UPDR:  return m ? SELDR : RTI;
            SELIR: return m ? TLR   : CAPIR;
            CAPIR: return m ? EX1IR : SHIR;
            SHIR:  return m ? EX1IR : SHIR;
            EX1IR: return m ? UPIR  : PAIR;
            PAIR:  return m ? EX2IR : PAIR;
            EX2IR: return m ? UPIR  : SHIR;
            default: return m ? SELDR : RTI;
        endcase
    endfunction

    always @(posedge tck or negedge tck or negedge trst) begin
        if (!trst) begin
            tap_st  <= TLR;
            ir      <= 2'b11;
            tdo_tap <= 1'b0;
        end else if (!use_sr8) begin
            if (tck) begin
                case (tap_st)
                    CAPDR: dr   <= {fa_carry, fa_sum, upd[2:0]};
                    SHDR:  dr   <= {tdi, dr[4:1]};
                    UPDR:  upd  <= dr;
                    CAPIR: irsr <= 2'b01;
                    SHIR:  irsr <= {tdi, irsr[1]};
                    UPIR:  ir   <= irsr;
                    default: ;
                endcase
                tap_st <= tap_next(tap_st, tms);
            end else begin
                if (tap_st == SHDR)      tdo_tap <= dr[0];
                else if (tap_st == SHIR) tdo_tap <= irsr[0];
            end
        end
    end

    // ---------------- drivers
    task automatic issue(input logic [1:0] op, input logic [5:0] len, input logic ex,
                         input logic [31:0] t, input logic [31:0] d);
        int n;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_asserts++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL issue_ready_timeout: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_len   = len;
        cmd_exit  = ex;
        cmd_tms   = t;
        cmd_tdi   = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_tms   = $urandom;
        cmd_tdi   = $urandom;
        cmd_len   = 6'($urandom);
    endtask

    // returns at the cycle rsp_valid is seen (cyc = cycles since accept), then acknowledges
    task automatic wait_rsp(output logic [31:0] val, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc = 0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        n_asserts++;
        if (!seen) begin
            n_fail++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1", rsp_valid);
        end
        val = rsp_tdo;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic run(input logic [1:0] op, input logic [5:0] len, input logic ex,
                       input logic [31:0] t, input logic [31:0] d, output logic [31:0] val);
        int cyc;
        issue(op, len, ex, t, d);
        wait_rsp(val, cyc);
    endtask

    // ---------------- tests
    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_asserts++;
        if ({cmd_ready, tck, tms, tdi, trst, rsp_valid} !== 6'b001010 || rsp_tdo !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: rdy/tck/tms/tdi/trst/vld=%b tdo=%h required 001010 0", {cmd_ready, tck, tms, tdi, trst, rsp_valid}, rsp_tdo);
        end
        rst = 1'b0;
        @(negedge clk);
        n_asserts++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after: cmd_ready=%b required 1", cmd_ready);
        end
    endtask

    task automatic test_seq;
        logic [31:0] v;
        tms_log.delete();
        exp_q.push_back(32'h0);
        run(2'd0, 6'd5, 1'b0, 32'h1F, 32'h0, v);
        n_asserts++;
        if (v !== exp_q.pop_front()) begin n_fail++; $display("FAIL seq_tlr_rsp: rsp_tdo=%h required 0", v); end
        exp_q.push_back(32'h0);
        run(2'd0, 6'd1, 1'b0, 32'h0, 32'h0, v);
        n_asserts++;
        if (v !== exp_q.pop_front()) begin n_fail++; $display("FAIL seq_rti_rsp: rsp_tdo=%h required 0", v); end
        n_asserts++;
        if (tms_log.size() != 6 || tms_log[0] !== 1'b1 || tms_log[4] !== 1'b1 || tms_log[5] !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_tms_pulses: pulses=%0d required 6 (1,1,1,1,1,0)", tms_log.size());
        end
        n_asserts++;
        if (tap_st !== RTI) begin n_fail++; $display("FAIL seq_tap_state: state=%0d required %0d", tap_st, RTI); end
    endtask

    task automatic test_shift8;
        logic [31:0] v;
        logic [7:0]  tms_seen;
        use_sr8 = 1'b1;
        sr8_load = 1'b1;
        #1;
        sr8_load = 1'b0;
        tms_log.delete();
        exp_q.push_back(32'h3C);
        run(2'd1, 6'd8, 1'b1, 32'h0, 32'hA5, v);
        n_asserts++;
        if (v !== exp_q.pop_front()) begin n_fail++; $display("FAIL shift8_rsp: rsp_tdo=%h required 3c", v); end
        n_asserts++;
        if (sr8 !== 8'hA5) begin n_fail++; $display("FAIL shift8_captured: model=%h required a5", sr8); end
        tms_seen = '0;
        for (int i = 0; i < 8 && i < tms_log.size(); i++) tms_seen[i] = tms_log[i];
        n_asserts++;
        if (tms_log.size() != 8 || tms_seen !== 8'h80) begin
            n_fail++;
            $display("FAIL shift8_tms: pulses=%0d tms=%h required 8 80", tms_log.size(), tms_seen);
        end
        use_sr8 = 1'b0;
    endtask

    task automatic test_latency;
        logic exp_tck;
        logic [31:0] v;
        exp_q.push_back(32'h0);
        issue(2'd1, 6'd3, 1'b0, 32'h0, 32'h5);
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            exp_tck = (c <= 24) && (((c - 1) % 8) >= 4);
            n_asserts++;
            if (tck !== exp_tck) begin n_fail++; $display("FAIL latency_tck c%0d: tck=%b required %b", c, tck, exp_tck); end
            n_asserts++;
            if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL latency_ready c%0d: cmd_ready=%b required 0", c, cmd_ready); end
            n_asserts++;
            if (rsp_valid !== (c == 25)) begin n_fail++; $display("FAIL latency_valid c%0d: rsp_valid=%b required %b", c, rsp_valid, c == 25); end
        end
        v = rsp_tdo;
        n_asserts++;
        if (v !== exp_q.pop_front()) begin n_fail++; $display("FAIL latency_rsp: rsp_tdo=%h required 0", v); end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        n_asserts++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL latency_idle: cmd_ready=%b required 1", cmd_ready); end
    endtask

    task automatic test_chain;
        logic [1:0]  ops[10]  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1};
        logic [5:0]  lens[10] = '{6'd5, 6'd1, 6'd4, 6'd2, 6'd2, 6'd3, 6'd5, 6'd2, 6'd3, 6'd5};
        logic [31:0] tmss[10] = '{32'h1F, 32'h0, 32'h3, 32'h0, 32'h1, 32'h1, 32'h0, 32'h1, 32'h1, 32'h0};
        logic [31:0] tdis[10] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h03, 32'h0, 32'h0, 32'h0};
        logic [31:0] exps[10] = '{32'h0, 32'h0, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h13};
        logic [31:0] v;
        logic [31:0] e;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(exps[i]);
            run(ops[i], lens[i], 1'b1, tmss[i], tdis[i], v);
            e = exp_q.pop_front();
            n_asserts++;
            if (v !== e) begin n_fail++; $display("FAIL chain_step%0d: rsp_tdo=%h required %h", i, v, e); end
        end
        n_asserts++;
        if (ir !== 2'b00 || upd !== 5'b00011) begin
            n_fail++;
            $display("FAIL chain_bsr_load: ir=%b bsr=%b required 00 00011", ir, upd);
        end
        exp_q.push_back(32'h3);
        run(2'd0, 6'd2, 1'b0, 32'h1, 32'h0, v);
        n_asserts++;
        if (v !== exp_q.pop_front() || tap_st !== RTI) begin
            n_fail++;
            $display("FAIL chain_exit: rsp_tdo=%h state=%0d required 3 %0d", v, tap_st, RTI);
        end
    endtask

    task automatic test_stall;
        logic [31:0] e;
        int n;
        exp_q.push_back(32'h3);
        issue(2'd0, 6'd2, 1'b0, 32'h0, 32'h0);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        e = exp_q.pop_front();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_asserts++;
            if (rsp_valid !== 1'b1 || rsp_tdo !== e || cmd_ready !== 1'b0 || tck !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold c%0d: vld=%b tdo=%h rdy=%b tck=%b required 1 %h 0 0", c, rsp_valid, rsp_tdo, cmd_ready, tck, e);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        n_asserts++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: vld=%b rdy=%b required 0 1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_boundary;
        logic [31:0] v;
        int cyc;
        int lows;
        // len=0
        tms_log.delete();
        exp_q.push_back(32'h0);
        issue(2'd0, 6'd0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_rsp(v, cyc);
        n_asserts++;
        if (v !== exp_q.pop_front() || cyc != 1 || tms_log.size() != 0) begin
            n_fail++;
            $display("FAIL len0: rsp_tdo=%h cycle=%0d pulses=%0d required 0 1 0", v, cyc, tms_log.size());
        end
        // TRST pulse
        exp_q.push_back(32'h0);
        issue(2'd2, 6'd1, 1'b0, 32'h0, 32'h0);
        lows = 0;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (trst === 1'b0) lows++;
            n_asserts++;
            if (trst !== (c == 9) || tck !== 1'b0 || tms !== 1'b1 || rsp_valid !== (c == 9)) begin
                n_fail++;
                $display("FAIL trst_c%0d: trst=%b tck=%b tms=%b vld=%b required %b 0 1 %b", c, trst, tck, tms, rsp_valid, c == 9, c == 9);
            end
        end
        n_asserts++;
        if (lows != 8 || rsp_tdo !== exp_q.pop_front() || tap_st !== TLR) begin
            n_fail++;
            $display("FAIL trst_summary: low_cycles=%0d tdo=%h state=%0d required 8 0 %0d", lows, rsp_tdo, tap_st, TLR);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        // length clamp
        tms_log.delete();
        exp_q.push_back(32'h0);
        issue(2'd0, 6'd40, 1'b0, 32'hFFFF_FFFF, 32'h0);
        wait_rsp(v, cyc);
        n_asserts++;
        if (v !== exp_q.pop_front() || cyc != 257 || tms_log.size() != 32) begin
            n_fail++;
            $display("FAIL len_clamp: rsp_tdo=%h cycle=%0d pulses=%0d required 0 257 32", v, cyc, tms_log.size());
        end
        // reset during bit 3 of an 8-bit SHIFT
        issue(2'd1, 6'd8, 1'b0, 32'h0, 32'hFF);
        repeat (26) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_asserts++;
        if (tck !== 1'b0 || tms !== 1'b1 || cmd_ready !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_during: tck=%b tms=%b rdy=%b vld=%b required 0 1 0 0", tck, tms, cmd_ready, rsp_valid);
        end
        rst = 1'b0;
        @(negedge clk);
        n_asserts++;
        if (cmd_ready !== 1'b1 || tck !== 1'b0 || tms !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_after: rdy=%b tck=%b tms=%b required 1 0 1", cmd_ready, tck, tms);
        end
        lows = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || tck !== 1'b0) lows++;
        end
        n_asserts++;
        if (lows != 0) begin n_fail++; $display("FAIL midrst_quiet: active_cycles=%0d required 0", lows); end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_shift8();
        test_latency();
        test_chain();
        test_stall();
        test_boundary();
        n_asserts++;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: pending=%0d required 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/jtag_driver.md
Name: jtag_driver

Overview:
System-clock-domain JTAG master that bit-bangs tck/tms/tdi/trst into the jtag_test_logic/boundary-scan top level and captures tdo. It sits directly upstream of the TAP. Commands arrive on a valid/ready interface and results return on a valid/ready interface. Host bridges and benches use it to drive TAP state walks and DR/IR shifts (e.g. loading/reading the 5-cell BSR) without hand-toggling pins.

Parameters:
CLK_DIV, 4, clk cycles per tck half-period (>=1); tck period = 2*CLK_DIV clk cycles
MAX_LEN, 32, maximum bits per command; width of the tms/tdi/tdo vectors

Ports:
clk  input  1  system clock; the sole clock
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  driver idle and able to accept a command
cmd_op  input  2  0=SEQ (per-bit tms and tdi), 1=SHIFT (tdi data, tms low except optional exit), 2=TRST pulse, 3=reserved
cmd_len  input  6  bit count 1..MAX_LEN
cmd_exit  input  1  SHIFT only: drive tms=1 on the final bit
cmd_tms  input  MAX_LEN  SEQ tms bits, LSB first
cmd_tdi  input  MAX_LEN  tdi bits, LSB first
rsp_valid  output  1  result available
rsp_ready  input  1  consumer accepts result
rsp_tdo  output  MAX_LEN  captured tdo, bit i = sample for bit i, unused upper bits 0
tck  output  1  JTAG clock, idles low
tms  output  1  JTAG mode select
tdi  output  1  JTAG data in
trst  output  1  JTAG reset, active-low
tdo  input  1  JTAG data out from the TAP

Behaviour:
- Reset, synchronous: state IDLE, tck=0, tms=1, tdi=0, trst=1, cmd_ready=0 during rst and 1 from the first cycle after, rsp_valid=0, rsp_tdo=0, bit/phase counters=0.
- Reset mid-operation aborts the command at once. tck drops to 0 in the same registered cycle. No response is produced.
- States are IDLE, LOW, HIGH, TRST, DONE.
- IDLE: cmd_ready=1. A command is accepted on cmd_valid&&cmd_ready. It latches op, length, exit, tms, tdi, and clears rsp_tdo.
  - op 0/1 with len>=1: go to LOW for bit 0.
  - op 2: go to TRST.
  - op 3 or len=0: go directly to DONE with rsp_tdo=0 and no tck activity.
- len greater than MAX_LEN is clamped to MAX_LEN.
- LOW, CLK_DIV cycles: tck=0. On entry, tms and tdi are driven for bit i.
  - SEQ: tms=cmd_tms[i], tdi=cmd_tdi[i].
  - SHIFT: tdi=cmd_tdi[i], tms = cmd_exit && (i==len-1).
  - After CLK_DIV cycles go to HIGH.
- HIGH, CLK_DIV cycles: tck=1. tms and tdi are held stable across the whole bit.
  - tdo is sampled into rsp_tdo[i] on the last clk of HIGH, before the falling edge. The TAP updates tdo on the falling edge.
  - Then, if i==len-1, go to DONE. Otherwise i++ and go to LOW.
- Outputs are registered, so each bit occupies exactly 2*CLK_DIV cycles.
- After the last bit tck=0 and tms/tdi hold their last values until the next command.
- TRST: trst=0 for 2*CLK_DIV cycles with tck=0 and tms=1, then go to DONE with rsp_tdo=0.
- DONE: rsp_valid=1 and rsp_tdo stable. cmd_ready=0. On rsp_ready go to IDLE, with rsp_valid=0 the next cycle.
- rsp_ready held low stalls the driver indefinitely, with no tck activity.
- cmd_ready is never 1 while rsp_valid=1.
- Latency: command accepted at cycle 0. Bits occupy cycles 1..2*CLK_DIV*len. rsp_valid rises at cycle 2*CLK_DIV*len+1.
- cmd fields are don't-care outside the accept cycle.
- tdo is treated as synchronous to clk: tck is derived from clk and the TAP is combinational/registered on tck.

Test Plan:
1. CLK_DIV=4: SEQ len=5, cmd_tms=0x1F, then SEQ len=1, cmd_tms=0 -> 5 tck pulses with tms=1, then 1 with tms=0. TAP reaches Run-Test/Idle. rsp_tdo=0 for both.
2. SHIFT len=8, cmd_tdi=0xA5, cmd_exit=1, tdo driven by an 8-bit model shift register preloaded 0x3C, LSB out first -> rsp_tdo=0x3C. The model captures 0xA5. tms=1 only during bit 7.
3. CLK_DIV=4, SHIFT len=3, accept at cycle 0 -> tck high exactly in cycles 5-8, 13-16, 21-24. rsp_valid at cycle 25. cmd_ready=0 during cycles 1-25.
4. Full chain through top: IR/DR walk, then SHIFT len=5 of 0b00011 loading the BSR with a=1, b=1, c=0 -> readback SHIFT returns sum=0, carry=1 in the expected bit positions of rsp_tdo.
5. Hold rsp_ready=0 for 20 cycles after DONE -> rsp_valid and rsp_tdo stay stable, cmd_ready=0, tck=0. Then release -> IDLE next cycle.
6. Boundary cases:
   - len=0 -> rsp_valid at cycle 1, no tck.
   - op=2 -> trst low for 8 cycles.
   - rst asserted at bit 3 of a len=8 SHIFT -> tck=0, tms=1, cmd_ready=1 after reset, no rsp_valid.
